// File: rtl/sdram_rom_loader.sv
// ROM download byte stream -> 16-bit single-word writes on a toggle req/ack SDRAM port.
// Define LOADER_BYTESWAP_EN to store packed words byte-swapped (even byte in d[15:8]).
`timescale 1ns/1ps
module sdram_rom_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 23
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [AW:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    output logic          sdram_req,
    input  logic          sdram_ack,
    output logic          sdram_we,
    output logic [AW-1:0] sdram_a,
    output logic [1:0]    sdram_ds,
    output logic [15:0]   sdram_d,
    output logic          load_done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = AW + 18;
`ifdef LOADER_BYTESWAP_EN
    localparam logic [1:0] EVEN_DS = 2'b10;
`else
    localparam logic [1:0] EVEN_DS = 2'b01;
`endif
    localparam logic [1:0] ODD_DS = ~EVEN_DS;

    typedef enum logic [1:0] {S_SYNC, S_IDLE, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic            hold_v_q, hold_v_d;
    logic [AW-1:0]   hold_a_q, hold_a_d;
    logic [1:0]      hold_ds_q, hold_ds_d;
    logic [15:0]     hold_dat_q, hold_dat_d;
    logic            seen_q, seen_d;
    logic            req_q, req_d;
    logic [AW-1:0]   a_q, a_d;
    logic [1:0]      ds_q, ds_d;
    logic [15:0]     d_q, d_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]     cnt_q, cnt_d;

    logic            strobe, push, push_ok, pop, full, empty, done;
    logic [AW-1:0]   waddr;
    logic [1:0]      lane;
    logic [15:0]     lmask, bdat, merged;
    logic [EW-1:0]   push_e;

    assign strobe = ioctl_wr & ioctl_download;
    assign waddr  = ioctl_addr[AW:1];
    assign lane   = ioctl_addr[0] ? ODD_DS : EVEN_DS;
    assign lmask  = {{8{lane[1]}}, {8{lane[0]}}};
    assign bdat   = {ioctl_dout, ioctl_dout} & lmask;
    assign merged = (hold_dat_q & ~lmask) | bdat;

    // Pack register: at most one push per cycle; a lone odd byte that
    // arrives together with a flush waits here and goes out next cycle.
    always_comb begin
        hold_v_d   = hold_v_q;
        hold_a_d   = hold_a_q;
        hold_ds_d  = hold_ds_q;
        hold_dat_d = hold_dat_q;
        push       = 1'b0;
        push_e     = {hold_a_q, hold_ds_q, hold_dat_q};
        if (strobe) begin
            if (hold_v_q && hold_a_q == waddr) begin
                hold_dat_d = merged;
                if ((hold_ds_q & lane) == 2'b00) begin
                    push     = 1'b1;
                    push_e   = {waddr, 2'b11, merged};
                    hold_v_d = 1'b0;
                end
            end else begin
                if (hold_v_q)
                    push = 1'b1;
                if (hold_v_q || !ioctl_addr[0]) begin
                    hold_v_d   = 1'b1;
                    hold_a_d   = waddr;
                    hold_ds_d  = lane;
                    hold_dat_d = bdat;
                end else begin
                    push   = 1'b1;
                    push_e = {waddr, lane, bdat};
                end
            end
        end else if (hold_v_q && (!ioctl_download || hold_ds_q == ODD_DS)) begin
            push     = 1'b1;
            hold_v_d = 1'b0;
        end
    end

    assign full       = cnt_q == (PW+1)'(FIFO_DEPTH);
    assign empty      = cnt_q == '0;
    assign push_ok    = push & (~full | pop);
    assign ioctl_wait = cnt_q >= (PW+1)'(FIFO_DEPTH - 1);

    always_comb begin
        wp_d  = push_ok ? wp_q + PW'(1) : wp_q;
        rp_d  = pop ? rp_q + PW'(1) : rp_q;
        cnt_d = cnt_q;
        if (push_ok && !pop)
            cnt_d = cnt_q + (PW+1)'(1);
        else if (!push_ok && pop)
            cnt_d = cnt_q - (PW+1)'(1);
    end

    always_ff @(posedge clk)
        if (push_ok)
            mem_q[wp_q] <= push_e;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_SYNC;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_SYNC:  state_d = S_IDLE;
            S_IDLE:  if (!empty) state_d = S_WAIT;
            S_WAIT:  if (sdram_ack == req_q) state_d = S_IDLE;
            default: state_d = S_SYNC;
        endcase
    end

    always_comb begin
        req_d = req_q;
        a_d   = a_q;
        ds_d  = ds_q;
        d_d   = d_q;
        pop   = 1'b0;
        unique case (state_q)
            S_SYNC: req_d = sdram_ack;
            S_IDLE: if (!empty) begin
                {a_d, ds_d, d_d} = mem_q[rp_q];
                req_d = ~req_q;
                pop   = 1'b1;
            end
            default: ;
        endcase
    end

    assign done = !ioctl_download && seen_q && !hold_v_q && empty
                  && state_q == S_IDLE;
    assign seen_d = ioctl_download | (seen_q & ~done);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_v_q   <= 1'b0;
            hold_a_q   <= '0;
            hold_ds_q  <= '0;
            hold_dat_q <= '0;
            seen_q     <= 1'b0;
            req_q      <= 1'b0;
            a_q        <= '0;
            ds_q       <= '0;
            d_q        <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
        end else begin
            hold_v_q   <= hold_v_d;
            hold_a_q   <= hold_a_d;
            hold_ds_q  <= hold_ds_d;
            hold_dat_q <= hold_dat_d;
            seen_q     <= seen_d;
            req_q      <= req_d;
            a_q        <= a_d;
            ds_q       <= ds_d;
            d_q        <= d_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
        end
    end

    assign sdram_req = req_q;
    assign sdram_we  = 1'b1;
    assign sdram_a   = a_q;
    assign sdram_ds  = ds_q;
    assign sdram_d   = d_q;
    assign load_done = done;

endmodule

// File: tb/tb_sdram_rom_loader.sv
// Scoreboard bench for sdram_rom_loader: byte-level reference model, toggle-ack controller model.
`timescale 1ns/1ps
module tb_sdram_rom_loader;

    localparam int AW = 23;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [1:0]    ds;
        logic [15:0]   d;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [AW:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_dout = '0;
    logic          ioctl_wait;
    logic          sdram_req;
    logic          sdram_ack = 1'b0;
    logic          sdram_we;
    logic [AW-1:0] sdram_a;
    logic [1:0]    sdram_ds;
    logic [15:0]   sdram_d;
    logic          load_done;

    sdram_rom_loader #(.FIFO_DEPTH(4), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_we(sdram_we),
        .sdram_a(sdram_a), .sdram_ds(sdram_ds), .sdram_d(sdram_d),
        .load_done(load_done)
    );

    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_err = 0;
    int  writes = 0;
    int  done_cnt = 0;
    int  lat = 3;
    bit  ctrl_hold = 0;
    bit  wait_seen = 0;
    wr_t exp_q[$];

    // reference model: only a pending even byte is ever held
    bit            pv = 0;
    logic [AW-1:0] pw;
    logic [7:0]    pbe;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void emit(input logic [AW-1:0] w, input bit he,
                                 input bit ho, input logic [7:0] be,
                                 input logic [7:0] bo);
        wr_t t;
        t.a = w;
`ifdef LOADER_BYTESWAP_EN
        t.ds = {he, ho};
        t.d  = {he ? be : 8'h00, ho ? bo : 8'h00};
`else
        t.ds = {ho, he};
        t.d  = {ho ? bo : 8'h00, he ? be : 8'h00};
`endif
        exp_q.push_back(t);
    endfunction

    function automatic void model_byte(input logic [AW:0] addr,
                                       input logic [7:0] b);
        logic [AW-1:0] w = addr[AW:1];
        if (pv && pw != w) begin
            emit(pw, 1, 0, pbe, 8'h00);
            pv = 0;
        end
        if (!addr[0]) begin
            pv  = 1;
            pw  = w;
            pbe = b;
        end else if (pv) begin
            emit(w, 1, 1, pbe, b);
            pv = 0;
        end else begin
            emit(w, 0, 1, 8'h00, b);
        end
    endfunction

    function automatic void model_fall();
        if (pv) emit(pw, 1, 0, pbe, 8'h00);
        pv = 0;
    endfunction

    // monitor + controller model, one process so ack never races the sample
    initial begin
        logic req_prev = 1'b0;
        int   cnt = 0;
        wr_t  e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (sdram_req !== req_prev && sdram_req !== sdram_ack) begin
                    writes++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 64'(sdram_a), 64'h0);
                        chk("unexpected_write_q", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 64'(sdram_a), 64'(e.a));
                        chk("wr_ds", 64'(sdram_ds), 64'(e.ds));
                        chk("wr_data", 64'(sdram_d), 64'(e.d));
                        chk("wr_we", 64'(sdram_we), 64'(1));
                    end
                end
                if (load_done) done_cnt++;
                if (ioctl_wait) wait_seen = 1;
            end
            req_prev = sdram_req;
            if (!reset && !ctrl_hold && sdram_req !== sdram_ack) begin
                cnt++;
                if (cnt >= lat) begin
                    sdram_ack = sdram_req;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [AW:0] a, input logic [7:0] b,
                             input int idle_pct);
        int g = 0;
        while (ioctl_wait || int'($urandom_range(99)) < idle_pct) begin
            ioctl_wr = 1'b0;
            tick(1);
            g++;
            if (g > 5000) begin
                chk("wait_timeout", 64'(ioctl_wait), 64'(0));
                break;
            end
        end
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = b;
        model_byte(a, b);
        tick(1);
    endtask

    task automatic send_stream(input logic [AW:0] start, input int n,
                               input int idle_pct, input int jump_pct);
        logic [AW:0] a = start;
        for (int i = 0; i < n; i++) begin
            send_byte(a, 8'($urandom), idle_pct);
            if (int'($urandom_range(99)) < jump_pct)
                a = a + (AW+1)'($urandom_range(9, 2));
            else
                a = a + 1'b1;
        end
        ioctl_wr = 1'b0;
    endtask

    task automatic end_download(input string name);
        int d0 = done_cnt;
        int g = 0;
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        model_fall();
        while (done_cnt == d0 && g < 20000) begin
            tick(1);
            g++;
        end
        chk({name, "_drained"}, 64'(exp_q.size()), 64'(0));
        tick(5);
        chk({name, "_load_done"}, 64'(done_cnt - d0), 64'(1));
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_req"}, 64'(sdram_req), 64'(0));
        chk({name, "_a"}, 64'(sdram_a), 64'(0));
        chk({name, "_ds"}, 64'(sdram_ds), 64'(0));
        chk({name, "_d"}, 64'(sdram_d), 64'(0));
        chk({name, "_wait"}, 64'(ioctl_wait), 64'(0));
        chk({name, "_done"}, 64'(load_done), 64'(0));
    endtask

    initial begin
        int w0;
        tick(2);
        chk_reset_vals("reset");
        reset = 1'b0;
        tick(2);

        // scenario 1: one full word
        lat = 3;
        ioctl_download = 1'b1;
        send_byte(24'h0, 8'h11, 0);
        send_byte(24'h1, 8'h22, 0);
        ioctl_wr = 1'b0;
        w0 = writes;
        end_download("s1");
        chk("s1_writes", 64'(writes - w0), 64'(1));

        // scenario 2: lone even then lone odd
        ioctl_download = 1'b1;
        send_byte(24'h4, 8'hAA, 0);
        send_byte(24'h9, 8'hBB, 0);
        ioctl_wr = 1'b0;
        end_download("s2");

        // scenario 3: slow controller, back-to-back stream
        lat = 100;
        wait_seen = 0;
        w0 = writes;
        ioctl_download = 1'b1;
        send_stream(24'h10, 16, 0, 0);
        end_download("s3");
        chk("s3_wait_seen", 64'(wait_seen), 64'(1));
        chk("s3_writes", 64'(writes - w0), 64'(8));

        // scenario 4: reset with ack high
        ctrl_hold = 1;
        sdram_ack = 1'b1;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(3);
        chk("s4_req_sync", 64'(sdram_req), 64'(1));
        w0 = writes;
        tick(10);
        chk("s4_no_write", 64'(writes - w0), 64'(0));
        ctrl_hold = 0;
        lat = 4;
        ioctl_download = 1'b1;
        send_stream(24'h100, 6, 10, 30);
        end_download("s4");

        // scenario 5: reset while a write is outstanding
        ctrl_hold = 1;
        w0 = writes;
        ioctl_download = 1'b1;
        send_stream(24'h40, 6, 0, 0);
        tick(5);
        chk("s5_one_outstanding", 64'(writes - w0), 64'(1));
        reset = 1'b1;
        ioctl_download = 1'b0;
        #1;
        chk_reset_vals("s5_abort");
        exp_q.delete();
        pv = 0;
        tick(1);
        reset = 1'b0;
        ctrl_hold = 0;
        w0 = writes;
        tick(30);
        chk("s5_no_write", 64'(writes - w0), 64'(0));
        chk("s5_req_eq_ack", 64'(sdram_req), 64'(sdram_ack));

        // randomized downloads
        for (int k = 0; k < 6; k++) begin
            lat = int'($urandom_range(15, 2));
            ioctl_download = 1'b1;
            send_stream((AW+1)'($urandom_range(1 << 20)),
                        int'($urandom_range(40, 10)),
                        int'($urandom_range(50)), 20);
            end_download("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
